sha256_padder: RTL and testbench

SHA256_PADDER -- requirements
Module: sha256_padder

---
 rtl/sha256_pkg.sv | 27 ++
 rtl/sha256_pad_word.sv | 22 ++
 rtl/sha256_padder.sv | 179 +++++++++++++++++
 tb/tb_sha256_padder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, widths and padder state encoding.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int BLOCK_W     = BLOCK_WORDS * WORD_W;
  localparam int HASH_W      = 256;

  localparam logic [HASH_W-1:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_SEND,
    ST_WAIT,
    ST_EXTRA,
    ST_DONE
  } pad_state_t;

  // Message length in bits, as carried in the last two words of the final block.
  function automatic logic [63:0] bit_len(input logic [31:0] byte_cnt);
    return {29'b0, byte_cnt, 3'b000};
  endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// One block word after padding: keeps i_keep leading bytes, optionally drops 0x80
// into the first dropped byte, zeroes the remainder.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [2:0]        i_keep,
  input  logic              i_mark,
  output logic [WORD_W-1:0] o_word
);

  always_comb begin
    o_word = '0;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < i_keep)
        o_word[31-8*j -: 8] = i_word[31-8*j -: 8];
      else if (i_mark && (3'(j) == i_keep))
        o_word[31-8*j -: 8] = 8'h80;
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// Streams a big-endian byte message into 512-bit SHA-256 blocks, applies the
// standard padding, and sequences an external compression core to the digest.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter logic [63:0] MAX_BYTES = 64'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_W-1:0]   s_data,
  input  logic [2:0]          s_bytes,
  input  logic                s_last,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [BLOCK_W-1:0]  M_out,
  output logic [HASH_W-1:0]   H_chain,
  output logic                core_valid,
  input  logic [HASH_W-1:0]   core_H,
  input  logic                core_done,
  output logic [HASH_W-1:0]   digest,
  output logic                digest_valid
);

  pad_state_t r_state, w_next;

  logic [0:BLOCK_WORDS-1][WORD_W-1:0] r_buf, w_pad_buf;
  logic [3:0]                          r_w;
  logic [31:0]                         r_byte_cnt;
  logic [6:0]                          r_p;
  logic                                r_final, r_extra, r_extra_mark, r_last;
  logic [HASH_W-1:0]                   r_h, r_digest;
  logic                                r_digest_valid;

  logic                          w_accept;
  logic [32:0]                   w_cnt_sum;
  logic [31:0]                   w_cnt_next;
  logic [63:0]                   w_len;
  logic [BLOCK_WORDS-1:0][2:0]   w_keep;
  logic [BLOCK_WORDS-1:0]        w_mark;

  assign s_ready  = !rst && ((r_state == ST_IDLE) || (r_state == ST_FILL));
  assign w_accept = s_valid && s_ready;

  // Counter saturates at MAX_BYTES; anything past that is an illegal message anyway.
  assign w_cnt_sum  = {1'b0, r_byte_cnt} + 33'(s_bytes);
  assign w_cnt_next = ({31'b0, w_cnt_sum} > MAX_BYTES) ? MAX_BYTES[31:0] : w_cnt_sum[31:0];
  assign w_len      = bit_len(r_byte_cnt);

  // Per-word view of the 0x80 offset p: bytes before p survive, byte p gets 0x80.
  always_comb begin
    w_keep = '0;
    w_mark = '0;
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      if (r_p >= 7'(4*k + 4))
        w_keep[k] = 3'd4;
      else if (r_p > 7'(4*k))
        w_keep[k] = 3'(r_p - 7'(4*k));
      w_mark[k] = (r_p >= 7'(4*k)) && (r_p < 7'(4*k + 4));
    end
  end

  for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_pad
    sha256_pad_word u_pad_word (
      .i_word (r_buf[g]),
      .i_keep (w_keep[g]),
      .i_mark (w_mark[g]),
      .o_word (w_pad_buf[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_FILL: begin
        if (w_accept) begin
          if (s_last)             w_next = ST_PAD;
          else if (r_w == 4'd15)  w_next = ST_SEND;
          else                    w_next = ST_FILL;
        end
      end
      ST_PAD:   w_next = ST_SEND;
      ST_SEND:  w_next = ST_WAIT;
      ST_WAIT: begin
        if (core_done) begin
          if (r_final)      w_next = ST_DONE;
          else if (r_extra) w_next = ST_EXTRA;
          else if (r_last)  w_next = ST_PAD;
          else              w_next = ST_FILL;
        end
      end
      ST_EXTRA: w_next = ST_SEND;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf          <= '0;
      r_w            <= '0;
      r_byte_cnt     <= '0;
      r_p            <= '0;
      r_final        <= 1'b0;
      r_extra        <= 1'b0;
      r_extra_mark   <= 1'b0;
      r_last         <= 1'b0;
      r_h            <= SHA256_IV;
      r_digest       <= '0;
      r_digest_valid <= 1'b0;
    end else begin
      r_digest_valid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_FILL: begin
          if (w_accept) begin
            r_buf[r_w] <= s_data;
            r_w        <= r_w + 4'd1;
            r_byte_cnt <= w_cnt_next;
            if (r_state == ST_IDLE) r_h <= SHA256_IV;
            if (s_last) begin
              r_last <= 1'b1;
              r_p    <= {1'b0, r_w, 2'b00} + 7'(s_bytes);
            end
          end
        end
        ST_PAD: begin
          r_buf <= w_pad_buf;
          if (r_p <= 7'd55) begin
            r_buf[14] <= w_len[63:32];
            r_buf[15] <= w_len[31:0];
            r_final   <= 1'b1;
          end else begin
            // No room for the length: it goes in a trailing block, which also
            // carries the 0x80 if the message filled this block exactly.
            r_extra      <= 1'b1;
            r_extra_mark <= (r_p == 7'd64);
          end
        end
        ST_WAIT: begin
          if (core_done) begin
            r_h <= core_H;
            if (!r_final && !r_extra && !r_last) r_w <= '0;
          end
        end
        ST_EXTRA: begin
          r_buf     <= '0;
          r_buf[0]  <= r_extra_mark ? 32'h8000_0000 : 32'h0;
          r_buf[14] <= w_len[63:32];
          r_buf[15] <= w_len[31:0];
          r_final   <= 1'b1;
          r_extra   <= 1'b0;
        end
        ST_DONE: begin
          r_digest       <= r_h;
          r_digest_valid <= 1'b1;
          r_w            <= '0;
          r_byte_cnt     <= '0;
          r_p            <= '0;
          r_final        <= 1'b0;
          r_extra        <= 1'b0;
          r_extra_mark   <= 1'b0;
          r_last         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign M_out        = r_buf;
  assign H_chain      = r_h;
  assign core_valid   = (r_state == ST_SEND);
  assign digest       = r_digest;
  assign digest_valid = r_digest_valid;

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench: behavioural SHA-256 core, byte-level padding reference,
// table vectors, reset-in-WAIT sequence and random messages.
module tb_sha256_padder;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  s_data = '0;
  logic [2:0]   s_bytes = '0;
  logic         s_last = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [511:0] M_out;
  logic [255:0] H_chain;
  logic         core_valid;
  logic [255:0] core_H = '0;
  logic         core_done = 1'b0;
  logic [255:0] digest;
  logic         digest_valid;

  always #5 clk = ~clk;

  sha256_padder dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_bytes      (s_bytes),
    .s_last       (s_last),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .M_out        (M_out),
    .H_chain      (H_chain),
    .core_valid   (core_valid),
    .core_H       (core_H),
    .core_done    (core_done),
    .digest       (digest),
    .digest_valid (digest_valid)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]   msg[$];
  logic [511:0] exp_blocks[$];
  logic [511:0] got_blocks[$];
  logic [255:0] got_digests[$];
  logic [255:0] exp_digest;
  int           rdy_at_capture = 0;
  bit           unstable = 1'b0;

  bit           job_busy = 1'b0;
  bit           job_abort = 1'b0;
  int           job_cnt = 0;
  int           core_lat = 3;
  logic [511:0] job_m;
  logic [255:0] job_h;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96]  + e, hin[95:64]   + f, hin[63:32]   + g, hin[31:0]    + h};
  endfunction

  // Core stand-in: takes M_out/H_chain when core_valid is seen, answers core_lat cycles later.
  always @(negedge clk) begin
    if (core_done) core_done = 1'b0;
    if (job_busy) begin
      if (rst) job_abort = 1'b1;
      if (!job_abort && (M_out !== job_m || H_chain !== job_h)) unstable = 1'b1;
      job_cnt--;
      if (job_cnt <= 0) begin
        core_H    = compress(job_h, job_m);
        core_done = 1'b1;
        job_busy  = 1'b0;
      end
    end
    if (core_valid && !rst) begin
      got_blocks.push_back(M_out);
      if (s_ready) rdy_at_capture++;
      job_m     = M_out;
      job_h     = H_chain;
      job_cnt   = core_lat;
      job_busy  = 1'b1;
      job_abort = 1'b0;
    end
    if (digest_valid) got_digests.push_back(digest);
  end

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference padding done on a flat byte list, then hashed block by block.
  task automatic build_expected();
    logic [7:0]   p[$];
    logic [63:0]  bl;
    logic [511:0] blk;
    logic [255:0] h;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    exp_blocks.delete();
    h = IV;
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = p[64*b + i];
      exp_blocks.push_back(blk);
      h = compress(h, blk);
    end
    exp_digest = h;
  endtask

  task automatic send_msg(input bit gaps);
    int n, nw, nb, tmo;
    logic [31:0] d;
    n  = msg.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      nb = (n - 4*i > 4) ? 4 : n - 4*i;
      for (int j = 0; j < 4; j++)
        d[31-8*j -: 8] = (4*i + j < n) ? msg[4*i + j] : 8'($urandom);
      @(negedge clk);
      s_data  = d;
      s_bytes = 3'(nb);
      s_last  = (i == nw - 1);
      s_valid = 1'b1;
      tmo = 0;
      #1;
      while (!s_ready && tmo < 3000) begin
        @(negedge clk);
        #1;
        tmo++;
      end
      if (!s_ready) begin
        check("accept_ready_timeout", 512'(s_ready), 512'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_msg(input string tag, input bit gaps);
    int nmin;
    got_blocks.delete();
    got_digests.delete();
    rdy_at_capture = 0;
    unstable = 1'b0;
    build_expected();
    send_msg(gaps);
    for (int c = 0; c < 4000 && got_digests.size() == 0; c++) @(posedge clk);
    repeat (6) @(posedge clk);
    check({tag, "_digest_pulses"}, 512'(got_digests.size()), 512'd1);
    if (got_digests.size() > 0) check({tag, "_digest"}, 512'(got_digests[0]), 512'(exp_digest));
    check({tag, "_block_count"}, 512'(got_blocks.size()), 512'(exp_blocks.size()));
    nmin = (got_blocks.size() < exp_blocks.size()) ? got_blocks.size() : exp_blocks.size();
    for (int i = 0; i < nmin; i++)
      check($sformatf("%s_block%0d", tag, i), got_blocks[i], exp_blocks[i]);
    check({tag, "_ready_low_in_send"}, 512'(rdy_at_capture), 512'd0);
    check({tag, "_block_held_in_wait"}, 512'(unstable), 512'd0);
  endtask

  typedef struct {
    int           len;
    logic [7:0]   b0;
    logic [7:0]   inc;
    int           nblk;
    bit           chk_dig;
    logic [255:0] dig;
    bit           chk_blk;
    logic [511:0] last_blk;
  } vec_t;

  vec_t vt [5];

  initial begin
    vt[0] = '{3, 8'h61, 8'h01, 1, 1'b1,
              256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 1'b0, '0};
    vt[1] = '{0, 8'h00, 8'h00, 1, 1'b1,
              256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, 1'b1,
              {32'h8000_0000, 480'h0}};
    vt[2] = '{55, 8'h61, 8'h00, 1, 1'b0, '0, 1'b0, '0};
    vt[3] = '{56, 8'h61, 8'h00, 2, 1'b0, '0, 1'b1, {448'h0, 64'h1C0}};
    vt[4] = '{64, 8'h61, 8'h00, 2, 1'b1,
              256'hffe054fe7ae0cb6dc65c3af9b61d5209f439851db43d0ba5997337df154668eb, 1'b1,
              {32'h8000_0000, 416'h0, 64'h200}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_s_ready", 512'(s_ready), 512'd0);
    check("rst_core_valid", 512'(core_valid), 512'd0);
    check("rst_digest_valid", 512'(digest_valid), 512'd0);
    check("rst_digest", 512'(digest), 512'd0);
    check("rst_M_out", M_out, 512'd0);
    check("rst_H_chain", 512'(H_chain), 512'(IV));
    rst = 1'b0;
    #1;
    check("rst_release_s_ready", 512'(s_ready), 512'd1);

    for (int i = 0; i < 5; i++) begin
      msg.delete();
      for (int j = 0; j < vt[i].len; j++) msg.push_back(8'(vt[i].b0 + 8'(j) * vt[i].inc));
      core_lat = 2 + i;
      run_msg($sformatf("vec%0d", i), 1'b0);
      check($sformatf("vec%0d_core_valid_count", i), 512'(got_blocks.size()), 512'(vt[i].nblk));
      if (vt[i].chk_dig && got_digests.size() > 0)
        check($sformatf("vec%0d_known_digest", i), 512'(got_digests[0]), 512'(vt[i].dig));
      if (vt[i].chk_blk && got_blocks.size() > 0)
        check($sformatf("vec%0d_last_block", i), got_blocks[got_blocks.size()-1], vt[i].last_blk);
    end

    // Reset while the core is busy; its late answer must not leak into the next message.
    msg = '{8'h61, 8'h62, 8'h63};
    core_lat = 12;
    got_blocks.delete();
    got_digests.delete();
    send_msg(1'b0);
    for (int c = 0; c < 100 && got_blocks.size() == 0; c++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 100 && job_busy; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    #1;
    check("rst_wait_no_stale_digest", 512'(got_digests.size()), 512'd0);
    check("rst_wait_idle_ready", 512'(s_ready), 512'd1);
    check("rst_wait_H_chain_iv", 512'(H_chain), 512'(IV));
    core_lat = 3;
    run_msg("abc_after_rst", 1'b0);
    if (got_digests.size() > 0)
      check("abc_after_rst_known_digest", 512'(got_digests[0]),
            512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));

    for (int r = 0; r < 12; r++) begin
      int len;
      len = $urandom_range(0, 140);
      msg.delete();
      for (int j = 0; j < len; j++) msg.push_back(8'($urandom));
      core_lat = $urandom_range(1, 6);
      run_msg($sformatf("rand%0d_len%0d", r, len), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
